// File: rtl/sim_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sim_ctrl_pkg
// Shared definitions for the simulation-control event sequencer and the
// host-side decode: sequencer state encoding and the evt_kind values.
// -----------------------------------------------------------------------------
package sim_ctrl_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        STOPPED = 2'd2,
        DONE    = 2'd3
    } sim_state_e;

    // evt_kind encodings seen by the host
    localparam logic [1:0] KIND_STOP    = 2'd0;
    localparam logic [1:0] KIND_FINISH  = 2'd1;
    localparam logic [1:0] KIND_TIMEOUT = 2'd2;

    // Map a requester's finish flag onto the reported event kind
    function automatic logic [1:0] kind_of(input logic finish);
        return finish ? KIND_FINISH : KIND_STOP;
    endfunction

endpackage

// File: rtl/sim_event_prio_sel.sv
// -----------------------------------------------------------------------------
// sim_event_prio_sel
// Combinational event picker: any finish request beats every stop request;
// within the chosen class the lowest index wins.
// Ports:
//   valid  [N_REQ]  requester raising an event
//   finish [N_REQ]  1 = finish, 0 = stop (only meaningful with valid)
//   any             at least one valid requester
//   idx    [IDX_W]  index of the winner (0 when none)
//   onehot [N_REQ]  one-hot winner (all zero when none)
// -----------------------------------------------------------------------------
module sim_event_prio_sel #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [N_REQ-1:0] finish,
    output logic             any,
    output logic [IDX_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    logic [N_REQ-1:0] fin_s;
    logic [N_REQ-1:0] cand_s;

    // Narrow the candidate set to finish requests when any exist, then scan
    // from the top down so the lowest set index is the last one written.
    always_comb begin
        fin_s  = valid & finish;
        cand_s = (|fin_s) ? fin_s : valid;
        idx    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = cand_s[i] ? IDX_W'(i) : idx;
        end
        onehot      = '0;
        onehot[idx] = |cand_s;
    end

    assign any = |cand_s;

endmodule

// File: rtl/sim_event_ctrl.sv
// -----------------------------------------------------------------------------
// sim_event_ctrl
// Run/halt sequencer for DUT-side $stop/$finish events. Arbitrates requesters,
// gates the design run enable, counts run cycles, enforces a cycle budget and
// holds the winning event for the host.
// Optional feature macro: SIM_EVENT_CTRL_STOP_COUNT_EN adds stop_count[15:0],
// a saturating count of stop grants cleared only by reset.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           begin a run (IDLE or DONE only)
//   timeout_limit   run-cycle budget, 0 = none
//   req_valid/req_finish/req_code   per-requester event inputs
//   req_ack         one-hot grant pulse
//   host_resume     leave STOPPED
//   run             DUT clock enable
//   cycle_count     run cycles in the current run
//   evt_valid/evt_kind/evt_src/evt_code   latched event for the host
// -----------------------------------------------------------------------------
module sim_event_ctrl
    import sim_ctrl_pkg::*;
#(
    parameter int  N_REQ  = 4,
    parameter int  CODE_W = 8,
    parameter int  CNT_W  = 32,
    localparam int SRC_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [CNT_W-1:0]        timeout_limit,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_finish,
    input  logic [N_REQ*CODE_W-1:0] req_code,
    output logic [N_REQ-1:0]        req_ack,
    input  logic                    host_resume,
    output logic                    run,
    output logic [CNT_W-1:0]        cycle_count,
    output logic                    evt_valid,
    output logic [1:0]              evt_kind,
    output logic [SRC_W-1:0]        evt_src,
    output logic [CODE_W-1:0]       evt_code
`ifdef SIM_EVENT_CTRL_STOP_COUNT_EN
    ,
    output logic [15:0]             stop_count
`endif
);

    sim_state_e         state_r;
    sim_state_e         state_nxt_s;
    logic [CNT_W-1:0]   cycle_count_r;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic               evt_valid_r;
    logic [1:0]         evt_kind_r;
    logic [SRC_W-1:0]   evt_src_r;
    logic [CODE_W-1:0]  evt_code_r;

    logic               grant_any_s;
    logic [SRC_W-1:0]   grant_idx_s;
    logic [N_REQ-1:0]   grant_onehot_s;
    logic               grant_finish_s;
    logic [CODE_W-1:0]  grant_code_s;
    logic               in_run_s;
    logic               timeout_hit_s;

    sim_event_prio_sel #(
        .N_REQ (N_REQ),
        .IDX_W (SRC_W)
    ) u_prio_sel (
        .valid  (req_valid),
        .finish (req_finish),
        .any    (grant_any_s),
        .idx    (grant_idx_s),
        .onehot (grant_onehot_s)
    );

    assign in_run_s       = (state_r == RUN);
    assign grant_finish_s = req_finish[grant_idx_s];
    assign grant_code_s   = req_code[grant_idx_s*CODE_W +: CODE_W];
    // Count saturates instead of wrapping
    assign cnt_inc_s      = (cycle_count_r == {CNT_W{1'b1}}) ? cycle_count_r
                                                             : cycle_count_r + CNT_W'(1);
    // A pending request in the same cycle suppresses the timeout
    assign timeout_hit_s  = (timeout_limit != {CNT_W{1'b0}}) &&
                            (cycle_count_r == timeout_limit - CNT_W'(1)) &&
                            !(|req_valid);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_nxt_s = RUN;
                else       state_nxt_s = IDLE;
            end
            RUN: begin
                if (grant_any_s)        state_nxt_s = grant_finish_s ? DONE : STOPPED;
                else if (timeout_hit_s) state_nxt_s = DONE;
                else                    state_nxt_s = RUN;
            end
            STOPPED: begin
                if (host_resume) state_nxt_s = RUN;
                else             state_nxt_s = STOPPED;
            end
            DONE: begin
                if (start) state_nxt_s = RUN;
                else       state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State-decoded outputs: run enable and the same-cycle grant acknowledge
    always_comb begin
        run     = 1'b0;
        req_ack = '0;
        if (in_run_s) begin
            run     = 1'b1;
            req_ack = grant_onehot_s;
        end else begin
            run     = 1'b0;
            req_ack = '0;
        end
    end

    // Run-cycle counter and latched event record
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_count_r <= '0;
            evt_valid_r   <= 1'b0;
            evt_kind_r    <= 2'd0;
            evt_src_r     <= '0;
            evt_code_r    <= '0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        cycle_count_r <= '0;
                        evt_valid_r   <= 1'b0;
                        evt_kind_r    <= 2'd0;
                        evt_src_r     <= '0;
                        evt_code_r    <= '0;
                    end
                end
                RUN: begin
                    // The cycle in which the event is seen still counts
                    cycle_count_r <= cnt_inc_s;
                    if (grant_any_s) begin
                        evt_valid_r <= 1'b1;
                        evt_kind_r  <= kind_of(grant_finish_s);
                        evt_src_r   <= grant_idx_s;
                        evt_code_r  <= grant_code_s;
                    end else if (timeout_hit_s) begin
                        evt_valid_r <= 1'b1;
                        evt_kind_r  <= KIND_TIMEOUT;
                        evt_src_r   <= '0;
                        evt_code_r  <= '0;
                    end
                end
                STOPPED: begin
                    if (host_resume) evt_valid_r <= 1'b0;
                end
                default: begin
                    evt_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign cycle_count = cycle_count_r;
    assign evt_valid   = evt_valid_r;
    assign evt_kind    = evt_kind_r;
    assign evt_src     = evt_src_r;
    assign evt_code    = evt_code_r;

`ifdef SIM_EVENT_CTRL_STOP_COUNT_EN
    logic [15:0] stop_count_r;

    // Saturating tally of stop grants; start does not clear it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stop_count_r <= 16'h0000;
        end else if (in_run_s && grant_any_s && !grant_finish_s &&
                     (stop_count_r != 16'hFFFF)) begin
            stop_count_r <= stop_count_r + 16'h0001;
        end
    end

    assign stop_count = stop_count_r;
`endif

endmodule

// File: tb/tb_sim_event_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sim_event_ctrl
// Directed bench for sim_event_ctrl with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; registered outputs are
// read there, and the combinational acknowledge 1 unit later.
// -----------------------------------------------------------------------------
module tb_sim_event_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] timeout_limit;
    logic [3:0]  req_valid;
    logic [3:0]  req_finish;
    logic [31:0] req_code;
    logic [3:0]  req_ack;
    logic        host_resume;
    logic        run;
    logic [31:0] cycle_count;
    logic        evt_valid;
    logic [1:0]  evt_kind;
    logic [1:0]  evt_src;
    logic [7:0]  evt_code;
`ifdef SIM_EVENT_CTRL_STOP_COUNT_EN
    logic [15:0] stop_count;
`endif

    int tests_run;
    int tests_failed;

    sim_event_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .timeout_limit (timeout_limit),
        .req_valid     (req_valid),
        .req_finish    (req_finish),
        .req_code      (req_code),
        .req_ack       (req_ack),
        .host_resume   (host_resume),
        .run           (run),
        .cycle_count   (cycle_count),
        .evt_valid     (evt_valid),
        .evt_kind      (evt_kind),
        .evt_src       (evt_src),
        .evt_code      (evt_code)
`ifdef SIM_EVENT_CTRL_STOP_COUNT_EN
        ,
        .stop_count    (stop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        start         = 1'b0;
        timeout_limit = 32'd0;
        req_valid     = 4'b0000;
        req_finish    = 4'b0000;
        req_code      = 32'h0000_0000;
        host_resume   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic begin_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (run !== 1'b0 || evt_valid !== 1'b0 || cycle_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_state: run=%b evt_valid=%b count=%0d, want 0 0 0", run, evt_valid, cycle_count);
        end
        begin_run();
        tick();
        tick();
        tests_run++;
        if (run !== 1'b1 || cycle_count !== 32'd2) begin
            tests_failed++;
            $display("FAIL run_before_reset: run=%b count=%0d, want 1 2", run, cycle_count);
        end
        // Reset while a stop request is raised
        req_valid = 4'b0010;
        rst_n     = 1'b0;
        tick();
        tests_run++;
        if (run !== 1'b0 || req_ack !== 4'b0000 || evt_valid !== 1'b0 || cycle_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_run: run=%b ack=%b evt_valid=%b count=%0d, want 0 0000 0 0",
                     run, req_ack, evt_valid, cycle_count);
        end
        rst_n     = 1'b1;
        #1;
        tests_run++;
        if (req_ack !== 4'b0000 || run !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_no_ack: ack=%b run=%b, want 0000 0", req_ack, run);
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_finish();
        do_reset();
        begin_run();
        repeat (5) tick();
        tests_run++;
        if (cycle_count !== 32'd5) begin
            tests_failed++;
            $display("FAIL finish_pre_count: count=%0d, want 5", cycle_count);
        end
        req_valid  = 4'b0100;
        req_finish = 4'b0100;
        req_code   = 32'h00A5_0000;
        #1;
        tests_run++;
        if (req_ack !== 4'b0100) begin
            tests_failed++;
            $display("FAIL finish_ack: ack=%b, want 0100", req_ack);
        end
        tick();
        tests_run++;
        if (req_ack !== 4'b0000) begin
            tests_failed++;
            $display("FAIL finish_ack_pulse: ack=%b, want 0000", req_ack);
        end
        req_valid = 4'b0000;
        tests_run++;
        if (run !== 1'b0 || evt_valid !== 1'b1 || evt_kind !== 2'd1 ||
            evt_src !== 2'd2 || evt_code !== 8'hA5 || cycle_count !== 32'd6) begin
            tests_failed++;
            $display("FAIL finish_event: run=%b v=%b kind=%0d src=%0d code=%h count=%0d, want 0 1 1 2 a5 6",
                     run, evt_valid, evt_kind, evt_src, evt_code, cycle_count);
        end
        repeat (3) tick();
        tests_run++;
        if (cycle_count !== 32'd6 || evt_code !== 8'hA5 || run !== 1'b0) begin
            tests_failed++;
            $display("FAIL finish_hold: count=%0d code=%h run=%b, want 6 a5 0", cycle_count, evt_code, run);
        end
    endtask

    task automatic test_priority();
        do_reset();
        begin_run();
        req_valid  = 4'b1001;
        req_finish = 4'b1000;
        req_code   = 32'h3300_0011;
        #1;
        tests_run++;
        if (req_ack !== 4'b1000) begin
            tests_failed++;
            $display("FAIL prio_ack: ack=%b, want 1000", req_ack);
        end
        tick();
        req_valid = 4'b0001;
        #1;
        tests_run++;
        if (evt_kind !== 2'd1 || evt_src !== 2'd3 || evt_code !== 8'h33 || run !== 1'b0 || req_ack !== 4'b0000) begin
            tests_failed++;
            $display("FAIL prio_event: kind=%0d src=%0d code=%h run=%b ack=%b, want 1 3 33 0 0000",
                     evt_kind, evt_src, evt_code, run, req_ack);
        end
        repeat (3) tick();
        tests_run++;
        if (req_ack !== 4'b0000 || evt_src !== 2'd3) begin
            tests_failed++;
            $display("FAIL prio_loser_pending: ack=%b src=%0d, want 0000 3", req_ack, evt_src);
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_stop_resume();
        do_reset();
        begin_run();
        tick();
        tick();
        req_valid  = 4'b0010;
        req_finish = 4'b0000;
        req_code   = 32'h0000_5C00;
        #1;
        tests_run++;
        if (req_ack !== 4'b0010) begin
            tests_failed++;
            $display("FAIL stop_ack: ack=%b, want 0010", req_ack);
        end
        tick();
        req_valid = 4'b0000;
        tests_run++;
        if (run !== 1'b0 || evt_valid !== 1'b1 || evt_kind !== 2'd0 ||
            evt_src !== 2'd1 || evt_code !== 8'h5C || cycle_count !== 32'd3) begin
            tests_failed++;
            $display("FAIL stop_event: run=%b v=%b kind=%0d src=%0d code=%h count=%0d, want 0 1 0 1 5c 3",
                     run, evt_valid, evt_kind, evt_src, evt_code, cycle_count);
        end
        // start must be ignored while STOPPED
        start = 1'b1;
        repeat (10) tick();
        start = 1'b0;
        tests_run++;
        if (cycle_count !== 32'd3 || run !== 1'b0 || evt_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL stop_frozen: count=%0d run=%b v=%b, want 3 0 1", cycle_count, run, evt_valid);
        end
        host_resume = 1'b1;
        tick();
        host_resume = 1'b0;
        tests_run++;
        if (run !== 1'b1 || evt_valid !== 1'b0 || cycle_count !== 32'd3) begin
            tests_failed++;
            $display("FAIL resume: run=%b v=%b count=%0d, want 1 0 3", run, evt_valid, cycle_count);
        end
        // start must be ignored while RUN
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tests_run++;
        if (cycle_count !== 32'd5 || run !== 1'b1) begin
            tests_failed++;
            $display("FAIL resume_count: count=%0d run=%b, want 5 1", cycle_count, run);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        begin_run();
        req_valid  = 4'b0110;
        req_finish = 4'b0000;
        req_code   = 32'h0077_6600;
        #1;
        tests_run++;
        if (req_ack !== 4'b0010) begin
            tests_failed++;
            $display("FAIL b2b_first_ack: ack=%b, want 0010", req_ack);
        end
        tick();
        req_valid = 4'b0100;
        #1;
        tests_run++;
        if (evt_src !== 2'd1 || evt_code !== 8'h66 || req_ack !== 4'b0000) begin
            tests_failed++;
            $display("FAIL b2b_stopped: src=%0d code=%h ack=%b, want 1 66 0000", evt_src, evt_code, req_ack);
        end
        host_resume = 1'b1;
        tick();
        host_resume = 1'b0;
        #1;
        tests_run++;
        if (req_ack !== 4'b0100) begin
            tests_failed++;
            $display("FAIL b2b_second_ack: ack=%b, want 0100", req_ack);
        end
        tick();
        req_valid = 4'b0000;
        tests_run++;
        if (evt_src !== 2'd2 || evt_code !== 8'h77 || evt_kind !== 2'd0 || run !== 1'b0 || cycle_count !== 32'd2) begin
            tests_failed++;
            $display("FAIL b2b_second_event: src=%0d code=%h kind=%0d run=%b count=%0d, want 2 77 0 0 2",
                     evt_src, evt_code, evt_kind, run, cycle_count);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        timeout_limit = 32'd8;
        begin_run();
        repeat (7) tick();
        tests_run++;
        if (cycle_count !== 32'd7 || run !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_pre: count=%0d run=%b, want 7 1", cycle_count, run);
        end
        tick();
        tests_run++;
        if (run !== 1'b0 || evt_valid !== 1'b1 || evt_kind !== 2'd2 ||
            evt_src !== 2'd0 || evt_code !== 8'h00 || cycle_count !== 32'd8) begin
            tests_failed++;
            $display("FAIL timeout_event: run=%b v=%b kind=%0d src=%0d code=%h count=%0d, want 0 1 2 0 00 8",
                     run, evt_valid, evt_kind, evt_src, evt_code, cycle_count);
        end
        // Restart from DONE clears count and event
        begin_run();
        tests_run++;
        if (cycle_count !== 32'd0 || evt_valid !== 1'b0 || evt_kind !== 2'd0 || run !== 1'b1) begin
            tests_failed++;
            $display("FAIL restart: count=%0d v=%b kind=%0d run=%b, want 0 0 0 1", cycle_count, evt_valid, evt_kind, run);
        end
        repeat (7) tick();
        req_valid  = 4'b0001;
        req_finish = 4'b0000;
        req_code   = 32'h0000_0042;
        #1;
        tests_run++;
        if (req_ack !== 4'b0001) begin
            tests_failed++;
            $display("FAIL timeout_race_ack: ack=%b, want 0001", req_ack);
        end
        tick();
        req_valid = 4'b0000;
        tests_run++;
        if (evt_kind !== 2'd0 || evt_code !== 8'h42 || evt_valid !== 1'b1 || cycle_count !== 32'd8) begin
            tests_failed++;
            $display("FAIL timeout_race_event: kind=%0d code=%h v=%b count=%0d, want 0 42 1 8",
                     evt_kind, evt_code, evt_valid, cycle_count);
        end
        timeout_limit = 32'd0;
    endtask

`ifdef SIM_EVENT_CTRL_STOP_COUNT_EN
    task automatic test_stop_count();
        do_reset();
        begin_run();
        for (int k = 0; k < 3; k++) begin
            req_valid  = 4'b0001;
            req_finish = 4'b0000;
            tick();
            req_valid   = 4'b0000;
            host_resume = 1'b1;
            tick();
            host_resume = 1'b0;
        end
        tests_run++;
        if (stop_count !== 16'd3) begin
            tests_failed++;
            $display("FAIL stop_count: got %0d, want 3", stop_count);
        end
        req_valid  = 4'b0001;
        req_finish = 4'b0001;
        tick();
        req_valid  = 4'b0000;
        req_finish = 4'b0000;
        begin_run();
        tick();
        tests_run++;
        if (stop_count !== 16'd3) begin
            tests_failed++;
            $display("FAIL stop_count_after_start: got %0d, want 3", stop_count);
        end
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_finish();
        test_priority();
        test_stop_resume();
        test_back_to_back();
        test_timeout();
`ifdef SIM_EVENT_CTRL_STOP_COUNT_EN
        test_stop_count();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
